// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic single-transfer RAM responder with programmable wait states.
// Optional address-range error response enabled by defining WB_RAM_ERR_EN.
module wb_ram_slave #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q;
  logic [3:0]              sel_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdat_q;
  logic                    bad_q;
  logic [31:0]             dat_q;
  logic [31:0]             mem [DEPTH];

  logic                    req;
  logic                    latch;
  logic                    go_resp;
  logic [31:0]             offset;
  logic [ADDR_WIDTH-1:0]   in_idx;
  logic                    in_bad;
  logic                    cur_we;
  logic [3:0]              cur_sel;
  logic [ADDR_WIDTH-1:0]   cur_idx;
  logic [31:0]             cur_wdat;
  logic                    cur_bad;
  logic                    unused_ok;

  assign req    = wbs_cyc_i & wbs_stb_i;
  assign offset = wbs_addr_i - BASE_ADDR;
  assign in_idx = offset[ADDR_WIDTH+1:2];
`ifdef WB_RAM_ERR_EN
  assign in_bad = (offset >> (ADDR_WIDTH + 2)) != 32'd0;
`else
  assign in_bad = 1'b0;
`endif
  assign unused_ok = &{1'b0, offset[1:0], offset[31:ADDR_WIDTH+2]};

  // With zero wait states the RAM access happens on the request edge itself,
  // so the live bus fields are used in IDLE and the latched copies afterwards.
  assign cur_we   = (state_q == S_IDLE) ? wbs_we_i  : we_q;
  assign cur_sel  = (state_q == S_IDLE) ? wbs_sel_i : sel_q;
  assign cur_idx  = (state_q == S_IDLE) ? in_idx    : idx_q;
  assign cur_wdat = (state_q == S_IDLE) ? wbs_dat_i : wdat_q;
  assign cur_bad  = (state_q == S_IDLE) ? in_bad    : bad_q;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    go_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          latch = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      idx_q   <= '0;
      wdat_q  <= 32'd0;
      bad_q   <= 1'b0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        we_q   <= wbs_we_i;
        sel_q  <= wbs_sel_i;
        idx_q  <= in_idx;
        wdat_q <= wbs_dat_i;
        bad_q  <= in_bad;
      end
      if (go_resp && !cur_we && !cur_bad) dat_q <= mem[cur_idx];
    end
  end

  // NOTE: the RAM array has no reset; a reset only suppresses a pending write.
  always_ff @(posedge clk_i) begin
    if (go_resp && cur_we && !cur_bad && !rst_i) begin
      for (int n = 0; n < 4; n++) begin
        if (cur_sel[n]) mem[cur_idx][8*n +: 8] <= cur_wdat[8*n +: 8];
      end
    end
  end

  assign wbs_dat_o = dat_q;
  assign wbs_ack_o = (state_q == S_RESP) && !bad_q;
  assign wbs_err_o = (state_q == S_RESP) && bad_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: three instances with 1, 0 and 3 wait states.
// Build with WB_RAM_ERR_EN defined to exercise the error-response path.
module tb_wb_ram_slave;
  logic        clk = 1'b0;
  logic [2:0]  rst, cyc, stb, we, ack, err;
  logic [3:0]  sel  [3];
  logic [31:0] adr  [3];
  logic [31:0] wdat [3];
  logic [31:0] rdat [3];
  int checks = 0;
  int errors = 0;
  int lat;
  logic e;

  always #5 clk = ~clk;

  wb_ram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u0 (
    .clk_i(clk), .rst_i(rst[0]), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]),
    .wbs_we_i(we[0]), .wbs_sel_i(sel[0]), .wbs_addr_i(adr[0]), .wbs_dat_i(wdat[0]),
    .wbs_dat_o(rdat[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0]));
  wb_ram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]),
    .wbs_we_i(we[1]), .wbs_sel_i(sel[1]), .wbs_addr_i(adr[1]), .wbs_dat_i(wdat[1]),
    .wbs_dat_o(rdat[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1]));
  wb_ram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u2 (
    .clk_i(clk), .rst_i(rst[2]), .wbs_cyc_i(cyc[2]), .wbs_stb_i(stb[2]),
    .wbs_we_i(we[2]), .wbs_sel_i(sel[2]), .wbs_addr_i(adr[2]), .wbs_dat_i(wdat[2]),
    .wbs_dat_o(rdat[2]), .wbs_ack_o(ack[2]), .wbs_err_o(err[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transfer; returns edges from request to ack/err (99 on timeout).
  task automatic xfer(input int k, input logic w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, output int l, output logic es);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; sel[k] = s; adr[k] = a; wdat[k] = d;
    l = 99;
    es = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (ack[k] || err[k]) begin
        l = n;
        es = err[k];
        break;
      end
    end
    cyc[k] = 1'b0; stb[k] = 1'b0;
    step();
    check($sformatf("u%0d_pulse_end", k), {30'd0, ack[k], err[k]}, 32'd0);
  endtask

  task automatic do_wr(input int k, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input string tag);
    int l;
    logic es;
    xfer(k, 1'b1, s, a, d, l, es);
    check({tag, "_lat"}, l, exp_lat(k));
    check({tag, "_err"}, {31'd0, es}, 32'd0);
  endtask

  task automatic do_rd(input int k, input logic [31:0] a, input logic [31:0] x,
                       input string tag);
    int l;
    logic es;
    xfer(k, 1'b0, 4'hF, a, 32'h0, l, es);
    check({tag, "_lat"}, l, exp_lat(k));
    check({tag, "_err"}, {31'd0, es}, 32'd0);
    check({tag, "_dat"}, rdat[k], x);
  endtask

  initial begin
    rst = 3'b111; cyc = 3'b000; stb = 3'b000; we = 3'b000;
    for (int k = 0; k < 3; k++) begin
      sel[k] = 4'h0; adr[k] = 32'h0; wdat[k] = 32'h0;
    end
    step(); step();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("u%0d_rst_ackerr", k), {30'd0, ack[k], err[k]}, 32'd0);
      check($sformatf("u%0d_rst_dat", k), rdat[k], 32'h0);
    end
    rst = 3'b000;
    step();

    // Full-word write and readback, one wait state
    do_wr(0, 32'h10, 32'hDEADBEEF, 4'hF, "t1_wr");
    do_rd(0, 32'h10, 32'hDEADBEEF, "t1_rd");

    // Byte-lane merge and empty select
    do_wr(0, 32'h20, 32'h11223344, 4'hF, "t2_init");
    do_wr(0, 32'h20, 32'h0000AA00, 4'b0010, "t2_lane");
    do_rd(0, 32'h20, 32'h1122AA44, "t2_rd");
    do_wr(0, 32'h20, 32'hFFFFFFFF, 4'b0000, "t2_sel0");
    do_rd(0, 32'h20, 32'h1122AA44, "t2_rd0");

    // Zero wait states: back-to-back reads with strobe held high
    do_wr(1, 32'h0, 32'hA0A0A0A0, 4'hF, "t3_w0");
    do_wr(1, 32'h4, 32'hB1B1B1B1, 4'hF, "t3_w1");
    do_wr(1, 32'h8, 32'hC2C2C2C2, 4'hF, "t3_w2");
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF; adr[1] = 32'h0;
    step();
    check("t3_c1_ack", {31'd0, ack[1]}, 32'd1);
    check("t3_c1_dat", rdat[1], 32'hA0A0A0A0);
    adr[1] = 32'h4;
    step();
    check("t3_c2_ack", {31'd0, ack[1]}, 32'd0);
    step();
    check("t3_c3_ack", {31'd0, ack[1]}, 32'd1);
    check("t3_c3_dat", rdat[1], 32'hB1B1B1B1);
    adr[1] = 32'h8;
    step();
    check("t3_c4_ack", {31'd0, ack[1]}, 32'd0);
    step();
    check("t3_c5_ack", {31'd0, ack[1]}, 32'd1);
    check("t3_c5_dat", rdat[1], 32'hC2C2C2C2);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    step();
    check("t3_c6_ack", {31'd0, ack[1]}, 32'd0);

    // Three wait states: strobe dropped mid-wait aborts the write
    do_wr(2, 32'h14, 32'hCAFEF00D, 4'hF, "t4_init");
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF;
    adr[2] = 32'h14; wdat[2] = 32'hBAD0BAD0;
    step(); step(); step();
    stb[2] = 1'b0; cyc[2] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      check("t4_abort_quiet", {30'd0, ack[2], err[2]}, 32'd0);
    end
    do_rd(2, 32'h14, 32'hCAFEF00D, "t4_rd");

    // Out-of-range access
`ifdef WB_RAM_ERR_EN
    do_wr(0, 32'h0, 32'h13579BDF, 4'hF, "t5_init");
    do_rd(0, 32'h0, 32'h13579BDF, "t5_rd0");
    xfer(0, 1'b1, 4'hF, 32'h1000, 32'h5555AAAA, lat, e);
    check("t5_wr_lat", lat, 32'd2);
    check("t5_wr_err", {31'd0, e}, 32'd1);
    do_rd(0, 32'h0, 32'h13579BDF, "t5_rd1");
    xfer(0, 1'b0, 4'hF, 32'h1000, 32'h0, lat, e);
    check("t5_rd_err", {31'd0, e}, 32'd1);
    check("t5_rd_dat_hold", rdat[0], 32'h13579BDF);
`else
    do_wr(0, 32'h1000, 32'h5555AAAA, 4'hF, "t5_alias_wr");
    do_rd(0, 32'h0, 32'h5555AAAA, "t5_alias_rd");
`endif

    // Reset during the wait phase of a write
    do_wr(2, 32'h18, 32'h0F0F0F0F, 4'hF, "t6_init");
    do_rd(2, 32'h14, 32'hCAFEF00D, "t6_pre");
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF;
    adr[2] = 32'h18; wdat[2] = 32'h77777777;
    step(); step();
    rst[2] = 1'b1;
    step();
    check("t6_rst_ackerr", {30'd0, ack[2], err[2]}, 32'd0);
    check("t6_rst_dat", rdat[2], 32'h0);
    rst[2] = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      check("t6_quiet", {30'd0, ack[2], err[2]}, 32'd0);
    end
    do_rd(2, 32'h18, 32'h0F0F0F0F, "t6_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
